// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-boundary registers: skid-buffer state
// encoding and the per-stage payload/control widths of the rv32i core.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 128;
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_DATA_W = 64;
  localparam int EXMEM_CTRL_W = 9;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 6;

  localparam int STALL_CNT_W  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stall statistic; sticks at all-ones
// until cleared.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_value <= '0;
    end else if (inc && (r_value != '1)) begin
      r_value <= r_value + CNT_W'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-boundary register with valid/ready handshake, flush
// and stall counter. Define PIPE_STAGE_SKID_BUF_EN for the 2-entry skid mode.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int CNT_W  = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              r,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic w_inXfer;
  logic w_outXfer;

`ifdef PIPE_STAGE_SKID_BUF_EN

  skid_state_e       r_state;
  skid_state_e       w_nextState;
  logic [DATA_W-1:0] r_mainData;
  logic [CTRL_W-1:0] r_mainCtrl;
  logic [DATA_W-1:0] r_skidData;
  logic [CTRL_W-1:0] r_skidCtrl;

  // Ready depends only on registered state, breaking the out_ready_i path.
  assign in_ready_o  = (r_state != FULL) & ~r;
  assign out_valid_o = (r_state != EMPTY);
  assign w_inXfer    = in_valid_i & in_ready_o;
  assign w_outXfer   = out_valid_o & out_ready_i;

  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (flush_i) begin
      w_nextState = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_inXfer) w_nextState = ONE;
        ONE: begin
          if (w_inXfer && !w_outXfer) w_nextState = FULL;
          else if (!w_inXfer && w_outXfer) w_nextState = EMPTY;
        end
        FULL: if (w_outXfer) w_nextState = ONE;
        default: w_nextState = EMPTY;
      endcase
    end
  end

  // Control of an empty entry is zeroed so bubbles never carry live ctrl.
  always_ff @(posedge clk) begin
    if (r) begin
      r_mainData <= '0;
      r_mainCtrl <= '0;
      r_skidData <= '0;
      r_skidCtrl <= '0;
    end else if (flush_i) begin
      r_mainCtrl <= '0;
      r_skidCtrl <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inXfer) begin
            r_mainData <= in_data_i;
            r_mainCtrl <= in_ctrl_i;
          end
        end
        ONE: begin
          if (w_inXfer && w_outXfer) begin
            r_mainData <= in_data_i;
            r_mainCtrl <= in_ctrl_i;
          end else if (w_inXfer) begin
            r_skidData <= in_data_i;
            r_skidCtrl <= in_ctrl_i;
          end else if (w_outXfer) begin
            r_mainCtrl <= '0;
          end
        end
        FULL: begin
          if (w_outXfer) begin
            r_mainData <= r_skidData;
            r_mainCtrl <= r_skidCtrl;
            r_skidCtrl <= '0;
          end
        end
        default: begin
          r_mainCtrl <= '0;
          r_skidCtrl <= '0;
        end
      endcase
    end
  end

  assign out_data_o = r_mainData;
  assign out_ctrl_o = r_mainCtrl;

`else

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  assign in_ready_o  = ~r & (~r_valid | out_ready_i);
  assign out_valid_o = r_valid;
  assign w_inXfer    = in_valid_i & in_ready_o;
  assign w_outXfer   = r_valid & out_ready_i;

  // Payload is kept on a bubble; only valid and ctrl are cleared.
  always_ff @(posedge clk) begin
    if (r) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_inXfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data_i;
      r_ctrl  <= in_ctrl_i;
    end else if (w_outXfer) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end

  assign out_data_o = r_data;
  assign out_ctrl_o = r_ctrl;

`endif

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stallCnt (
    .clk   (clk),
    .inc   (out_valid_o & ~out_ready_i),
    .clear (r),
    .value (stall_cnt_o)
  );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-boundary register; successor to the fixed-field inter-stage latches of the pipelined rv32i core.
- Carries an opaque data payload plus a control bundle across a stage boundary.
- Valid/ready handshake, back-pressure, flush-to-bubble, a saturating stall counter, and an optional 2-entry skid buffer.
- Instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage widths.

Parameters:
- DATA_W, 64, payload bits (e.g. alu_result + store data); held, not cleared, on bubble.
- CTRL_W, 9, control bits (rd, reg_write, mem_read, ...); forced to 0 whenever the stage holds a bubble.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- r  in  1  synchronous active-high reset.
- flush_i  in  1  kill all held and incoming beats this cycle.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat.
- in_data_i  in  DATA_W  upstream payload.
- in_ctrl_i  in  CTRL_W  upstream control.
- out_valid_o  out  1  downstream beat valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  held payload.
- out_ctrl_o  out  CTRL_W  held control; 0 when out_valid_o=0.
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.

Behaviour:
- Interface is decided: one clock `clk`; reset `r` is synchronous and active-high.
- Reset (r=1 at a clk edge):
  - out_valid_o=0, out_data_o=0, out_ctrl_o=0, stall_cnt_o=0.
  - All internal entries are emptied.
  - in_ready_o=0 while r=1.
  - r has priority over flush and handshakes.
- Transfers:
  - Input transfer = in_valid_i & in_ready_o at the edge.
  - Output transfer = out_valid_o & out_ready_i at the edge.
- Base mode (no macro): single register.
  - in_ready_o = !out_valid_o | out_ready_i (combinational, 1 when not in reset).
  - On an input transfer: load data/ctrl; out_valid_o=1 next cycle. Latency is 1 cycle.
  - Output transfer with no input transfer: out_valid_o=0 and out_ctrl_o=0 next cycle; out_data_o holds.
  - Neither transfer: all outputs hold.
- Flush: at the edge with flush_i=1 (and r=0):
  - out_valid_o=0 and out_ctrl_o=0 next cycle; any input transfer that same edge is discarded.
  - Upstream still sees the handshake complete.
  - out_data_o is unchanged.
- Bubble invariant: out_valid_o=0 implies out_ctrl_o=0 in every cycle. Downstream stages may use ctrl without gating.
- Stall counter:
  - Increments by 1 each edge with out_valid_o & !out_ready_i & !r.
  - Saturates at 2^CNT_W-1.
  - Cleared only by r, never by flush_i.
- Downstream stall with no flush: held beat stable (data, ctrl, valid) until accepted. No drop, no duplication.

Optional Feature:
- Macro: PIPE_STAGE_SKID_BUF_EN.
- Defined: 2-entry buffer (main + skid) with state EMPTY/ONE/FULL.
  - in_ready_o is a register, = (state != FULL) & !r, with no combinational path from out_ready_i.
  - Transitions:
    - EMPTY+in -> ONE.
    - ONE+in&!out -> FULL, with the beat stored in skid.
    - ONE+in&out -> ONE.
    - ONE+out&!in -> EMPTY.
    - FULL+out -> ONE, with skid moving to main.
    - FULL with !out -> FULL.
  - Order is preserved, and throughput is 1 beat/cycle.
  - Flush -> EMPTY; skid contents are discarded.
- Undefined: base single-register mode as above. Port list is identical in both modes.

Decomposition:
- Shared package pipe_pkg:
  - Skid state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
  - Per-stage DATA_W/CTRL_W constants, e.g. EXMEM_DATA_W=64, EXMEM_CTRL_W=9.
- Sub-module: pipe_sat_counter (CNT_W, inc, clear, value) for the stall counter. The datapath stays in pipe_stage_reg.

Test Plan:
- Reset then stream: in_data_i=0x11..0x14, in_ctrl_i=0x1F5, out_ready_i=1 -> each beat appears 1 cycle later; out_valid_o=1 for 4 cycles; stall_cnt_o=0.
- Back-pressure: load 0xDEAD_BEEF, hold out_ready_i=0 for 5 cycles -> out_data_o stable, stall_cnt_o=5; base mode in_ready_o=0, skid mode accepts exactly 1 more beat then in_ready_o=0.
- Flush with input transfer: out_valid_o=1 holding ctrl=0x1FF, flush_i=1 and in_valid_i=1 same edge -> next cycle out_valid_o=0, out_ctrl_o=0, new beat absent.
- Reset mid-stall: FULL/stalled, stall_cnt_o=3, assert r one cycle -> all outputs 0, stall_cnt_o=0, in_ready_o=0 during r then 1.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt_o=15 and holds; flush_i does not clear it.
- Skid ordering (macro on): random out_ready_i, 1000 beats with incrementing data -> output sequence strictly incrementing, no gaps or duplicates, out_ctrl_o=0 whenever out_valid_o=0.
